// File: rtl/d_mem_fabric_ctrl.sv
// Fabric-side initiator for data memory port B: byte-addressed load/store requests in,
// byte-enabled word accesses out, formatted in-order responses through a credit-limited FIFO.
module d_mem_fabric_ctrl #(
   parameter int unsigned MSB_D_MEM      = 12,
   parameter int unsigned RSP_FIFO_DEPTH = 4,
   parameter int unsigned TAG_W          = 8
) (
   input  logic                 clock,
   input  logic                 rst_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_opcode,
   input  logic [MSB_D_MEM:0]   req_address,
   input  logic [1:0]           req_size,
   input  logic                 req_signed,
   input  logic [31:0]          req_data,
   input  logic [TAG_W-1:0]     req_tag,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [31:0]          rsp_data,
   output logic [TAG_W-1:0]     rsp_tag,
   output logic                 rsp_opcode,
   output logic                 rsp_error,
   output logic [MSB_D_MEM-2:0] address_b,
   output logic [3:0]           byteena_b,
   output logic [31:0]          data_b,
   output logic                 rden_b,
   output logic                 wren_b,
   input  logic [31:0]          q_b
);

   localparam int unsigned CNT_W = $clog2(RSP_FIFO_DEPTH + 1);
   localparam int unsigned PTR_W = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;
   localparam int unsigned ENT_W = TAG_W + 34;

   logic             accept, pop;
   logic             req_err;
   logic [3:0]       lanes;
   logic [31:0]      wdata;
   logic [CNT_W-1:0] inflight, inflight_next;
   logic [CNT_W-1:0] fcnt, fcnt_next;
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [ENT_W-1:0] fifo_mem [RSP_FIFO_DEPTH];

   logic             s1_valid, s1_err, s1_op, s1_signed;
   logic [1:0]       s1_size, s1_off;
   logic [TAG_W-1:0] s1_tag;
   logic             s2_valid, s2_err, s2_op, s2_signed;
   logic [1:0]       s2_size, s2_off;
   logic [TAG_W-1:0] s2_tag;
   logic [31:0]      shifted, fmt;

   assign accept = req_valid && req_ready;
   assign pop    = rsp_valid && rsp_ready;

   // Request decode: alignment check, lane pattern and write-data replication
   always_comb begin
      req_err = 1'b0;
      lanes   = 4'h0;
      wdata   = req_data;
      case (req_size)
         2'd0: begin
            lanes = 4'b0001 << req_address[1:0];
            wdata = {4{req_data[7:0]}};
         end
         2'd1: begin
            req_err = req_address[0];
            lanes   = 4'b0011 << req_address[1:0];
            wdata   = {2{req_data[15:0]}};
         end
         2'd2: begin
            req_err = (req_address[1:0] != 2'b00);
            lanes   = 4'hF;
         end
         default: req_err = 1'b1;
      endcase
   end

   // Credit count covers S1, S2 and FIFO occupancy
   always_comb begin
      inflight_next = inflight;
      if (accept && !pop)      inflight_next = inflight + CNT_W'(1);
      else if (!accept && pop) inflight_next = inflight - CNT_W'(1);
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         inflight  <= '0;
         req_ready <= 1'b1;
      end else begin
         inflight  <= inflight_next;
         req_ready <= (inflight_next < CNT_W'(RSP_FIFO_DEPTH));
      end
   end

   // S1: drive memory port B; errored requests travel without touching memory
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_err    <= 1'b0;
         s1_op     <= 1'b0;
         s1_signed <= 1'b0;
         s1_size   <= 2'd0;
         s1_off    <= 2'd0;
         s1_tag    <= '0;
         rden_b    <= 1'b0;
         wren_b    <= 1'b0;
         byteena_b <= 4'h0;
         address_b <= '0;
         data_b    <= '0;
      end else begin
         s1_valid  <= accept;
         rden_b    <= accept && !req_err && !req_opcode;
         wren_b    <= accept && !req_err && req_opcode;
         byteena_b <= (accept && !req_err) ? lanes : 4'h0;
         if (accept) begin
            s1_err    <= req_err;
            s1_op     <= req_opcode;
            s1_signed <= req_signed;
            s1_size   <= req_size;
            s1_off    <= req_address[1:0];
            s1_tag    <= req_tag;
            address_b <= req_address[MSB_D_MEM:2];
            data_b    <= wdata;
         end
      end
   end

   // S2: request context aligned with q_b
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid  <= 1'b0;
         s2_err    <= 1'b0;
         s2_op     <= 1'b0;
         s2_signed <= 1'b0;
         s2_size   <= 2'd0;
         s2_off    <= 2'd0;
         s2_tag    <= '0;
      end else begin
         s2_valid  <= s1_valid;
         s2_err    <= s1_err;
         s2_op     <= s1_op;
         s2_signed <= s1_signed;
         s2_size   <= s1_size;
         s2_off    <= s1_off;
         s2_tag    <= s1_tag;
      end
   end

   always_comb begin
      shifted = q_b >> {s2_off, 3'b000};
      case (s2_size)
         2'd0:    fmt = {{24{s2_signed & shifted[7]}}, shifted[7:0]};
         2'd1:    fmt = {{16{s2_signed & shifted[15]}}, shifted[15:0]};
         default: fmt = q_b;
      endcase
      if (s2_err || s2_op) fmt = 32'h0;
   end

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(RSP_FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_comb begin
      fcnt_next = fcnt;
      if (s2_valid && !pop)      fcnt_next = fcnt + CNT_W'(1);
      else if (!s2_valid && pop) fcnt_next = fcnt - CNT_W'(1);
   end

   // Response FIFO; credits guarantee a free slot for every S2 push
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         fcnt      <= '0;
         rsp_valid <= 1'b0;
         for (int i = 0; i < RSP_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      end else begin
         fcnt      <= fcnt_next;
         rsp_valid <= (fcnt_next != '0);
         if (s2_valid) begin
            fifo_mem[wr_ptr] <= {s2_err, s2_op, s2_tag, fmt};
            wr_ptr           <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
      end
   end

   assign {rsp_error, rsp_opcode, rsp_tag, rsp_data} = fifo_mem[rd_ptr];

endmodule

// File: tb/tb_d_mem_fabric_ctrl.sv
// Bench for d_mem_fabric_ctrl: memory model on port B, byte-level reference model,
// scoreboarded responses and port-B access expectations.
module tb_d_mem_fabric_ctrl;

   localparam int unsigned MSB   = 12;
   localparam int unsigned DEPTH = 4;
   localparam int unsigned TW    = 8;
   localparam int unsigned AW    = MSB + 1;
   localparam int unsigned WA    = MSB - 1;

   logic          clock = 1'b0;
   logic          rst_n = 1'b0;
   logic          req_valid = 1'b0, req_ready, req_opcode = 1'b0, req_signed = 1'b0;
   logic [AW-1:0] req_address = '0;
   logic [1:0]    req_size = 2'd0;
   logic [31:0]   req_data = '0;
   logic [TW-1:0] req_tag = '0;
   logic          rsp_valid, rsp_ready = 1'b1, rsp_opcode, rsp_error;
   logic [31:0]   rsp_data;
   logic [TW-1:0] rsp_tag;
   logic [WA-1:0] address_b;
   logic [3:0]    byteena_b;
   logic [31:0]   data_b, q_b = '0;
   logic          rden_b, wren_b;

   int checks = 0, failures = 0, cyc = 0;
   bit rnd_ready = 0;

   d_mem_fabric_ctrl #(.MSB_D_MEM(MSB), .RSP_FIFO_DEPTH(DEPTH), .TAG_W(TW)) dut (
      .clock(clock), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_address(req_address), .req_size(req_size),
      .req_signed(req_signed), .req_data(req_data), .req_tag(req_tag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
      .rsp_opcode(rsp_opcode), .rsp_error(rsp_error), .address_b(address_b),
      .byteena_b(byteena_b), .data_b(data_b), .rden_b(rden_b), .wren_b(wren_b), .q_b(q_b));

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Port B memory: byte-enabled write, 1-cycle synchronous read
   logic [31:0] mem_words [2**WA];
   always @(posedge clock) begin
      if (wren_b)
         for (int i = 0; i < 4; i++)
            if (byteena_b[i]) mem_words[address_b][8*i +: 8] <= data_b[8*i +: 8];
      if (rden_b) q_b <= mem_words[address_b];
   end

   typedef struct {
      logic [TW-1:0] tag; logic op; logic err; logic [31:0] data; int acc; bit lat;
   } rsp_t;
   typedef struct {
      int cyc; logic rd; logic wr; logic [3:0] be; logic [WA-1:0] addr; logic [31:0] data;
   } port_t;

   rsp_t  exp_q[$];
   port_t port_q[$];
   logic [7:0] ref_mem [2**AW];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Reference model: byte-addressed memory and access rules
   task automatic model(input logic op, input int addr, input int size, input logic sgn,
                        input logic [31:0] data, input logic [TW-1:0] tag, input bit lat);
      rsp_t  r;
      port_t p;
      int    nb, off;
      bit    err;
      nb  = 1 << size;
      off = addr % 4;
      err = (size == 3) || (size == 1 && (addr % 2) != 0) || (size == 2 && off != 0);
      r.tag = tag; r.op = op; r.err = err; r.data = '0; r.acc = cyc; r.lat = lat;
      p.cyc = cyc + 1; p.rd = 1'b0; p.wr = 1'b0; p.be = 4'h0;
      p.addr = WA'(addr / 4); p.data = '0;
      if (!err) begin
         p.rd = !op;
         p.wr = op;
         for (int i = 0; i < 4; i++) begin
            p.be[i] = (i >= off) && (i < off + nb);
            p.data[8*i +: 8] = data[8*(i % nb) +: 8];
         end
         if (op) begin
            for (int i = 0; i < nb; i++) ref_mem[addr + i] = data[8*i +: 8];
         end else begin
            for (int i = 0; i < nb; i++) r.data[8*i +: 8] = ref_mem[addr + i];
            if (sgn && nb < 4 && r.data[8*nb-1])
               for (int i = nb; i < 4; i++) r.data[8*i +: 8] = 8'hFF;
         end
      end
      exp_q.push_back(r);
      port_q.push_back(p);
   endtask

   task automatic drive(input logic op, input int addr, input int size, input logic sgn,
                        input logic [31:0] data, input logic [TW-1:0] tag);
      req_valid   = 1'b1;
      req_opcode  = op;
      req_address = AW'(addr);
      req_size    = 2'(size);
      req_signed  = sgn;
      req_data    = data;
      req_tag     = tag;
   endtask

   task automatic send(input logic op, input int addr, input int size, input logic sgn,
                       input logic [31:0] data, input logic [TW-1:0] tag, input bit lat);
      int waited = 0;
      drive(op, addr, size, sgn, data, tag);
      while (!req_ready && waited < 100) begin
         tick();
         waited++;
      end
      checks++;
      if (!req_ready) begin
         failures++;
         $display("FAIL accept_timeout: tag 0x%02h never accepted", tag);
      end else model(op, addr, size, sgn, data, tag, lat);
      tick();
      req_valid = 1'b0;
   endtask

   // Port B monitor: expected access one cycle after accept, otherwise idle
   always @(negedge clock) begin
      if (rst_n) begin
         if (port_q.size() > 0 && port_q[0].cyc == cyc) begin
            port_t p;
            p = port_q.pop_front();
            chk("port_rden", 32'(rden_b), 32'(p.rd));
            chk("port_wren", 32'(wren_b), 32'(p.wr));
            chk("port_byteena", 32'(byteena_b), 32'(p.be));
            if (p.rd || p.wr) chk("port_address", 32'(address_b), 32'(p.addr));
            if (p.wr) chk("port_data", data_b, p.data);
         end else begin
            chk("port_idle_en", 32'({rden_b, wren_b}), 32'h0);
            chk("port_idle_be", 32'(byteena_b), 32'h0);
         end
      end
   end

   // Response monitor: in-order scoreboard, latency and hold-while-stalled
   bit            hold = 0;
   logic [31:0]   held_data;
   logic [TW-1:0] held_tag;
   always @(negedge clock) begin
      if (!rst_n) hold = 0;
      else if (rsp_valid) begin
         if (hold) begin
            chk("rsp_hold_data", rsp_data, held_data);
            chk("rsp_hold_tag", 32'(rsp_tag), 32'(held_tag));
         end
         if (rsp_ready) begin
            hold = 0;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL rsp_unexpected: tag 0x%02h data 0x%08h", rsp_tag, rsp_data);
            end else begin
               rsp_t e;
               e = exp_q.pop_front();
               chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
               chk("rsp_opcode", 32'(rsp_opcode), 32'(e.op));
               chk("rsp_error", 32'(rsp_error), 32'(e.err));
               chk("rsp_data", rsp_data, e.data);
               if (e.lat) chk("rsp_latency", 32'(cyc - e.acc), 32'd3);
            end
         end else begin
            hold      = 1;
            held_data = rsp_data;
            held_tag  = rsp_tag;
         end
      end else hold = 0;
   end

   always @(posedge clock) begin
      #1;
      if (rnd_ready) rsp_ready = ($urandom_range(0, 2) != 0);
   end

   task automatic drain();
      int n = 0;
      while (exp_q.size() > 0 && n < 200) begin
         tick();
         n++;
      end
      chk("drain_empty", 32'(exp_q.size()), 32'h0);
      repeat (3) tick();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int acc, addr, size;
      for (int i = 0; i < 2**WA; i++) mem_words[i] = '0;
      for (int i = 0; i < 2**AW; i++) ref_mem[i] = '0;

      repeat (3) @(posedge clock);
      #2;
      chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("reset_port_en", 32'({rden_b, wren_b}), 32'h0);
      chk("reset_byteena", 32'(byteena_b), 32'h0);
      chk("reset_address_b", 32'(address_b), 32'h0);
      chk("reset_data_b", data_b, 32'h0);
      chk("reset_rsp_fields", {rsp_data[31:1], rsp_error ^ rsp_opcode ^ rsp_data[0]}, 32'h0);
      chk("reset_rsp_tag", 32'(rsp_tag), 32'h0);
      chk("reset_req_ready", 32'(req_ready), 32'h1);
      @(negedge clock);
      rst_n = 1'b1;
      tick();

      // Write then read back, byte/half extension, byte-lane write, error requests
      send(1'b1, 'h010, 2, 1'b0, 32'hDEADBEEF, 8'd1, 1);
      send(1'b0, 'h010, 2, 1'b0, 32'h0, 8'd2, 1);
      send(1'b0, 'h013, 0, 1'b1, 32'h0, 8'd3, 1);
      send(1'b0, 'h013, 0, 1'b0, 32'h0, 8'd4, 1);
      send(1'b0, 'h012, 1, 1'b1, 32'h0, 8'd5, 1);
      send(1'b0, 'h010, 1, 1'b0, 32'h0, 8'd6, 1);
      send(1'b1, 'h011, 0, 1'b0, 32'h00000055, 8'd7, 1);
      send(1'b0, 'h010, 2, 1'b0, 32'h0, 8'd8, 1);
      send(1'b0, 'h011, 1, 1'b0, 32'h0, 8'd9, 1);
      send(1'b1, 'h012, 2, 1'b0, 32'h12345678, 8'd10, 1);
      send(1'b0, 'h010, 2, 1'b0, 32'h0, 8'd11, 1);
      drain();

      // Credit limit with responses stalled
      rsp_ready = 1'b0;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         drive(1'b0, 'h010 + 4 * (i % 2), 2, 1'b0, 32'h0, TW'(i));
         if (req_ready) begin
            model(1'b0, 'h010 + 4 * (i % 2), 2, 1'b0, 32'h0, TW'(i), 0);
            acc++;
         end
         tick();
      end
      req_valid = 1'b0;
      chk("credit_accepted", 32'(acc), 32'd4);
      chk("credit_ready_low", 32'(req_ready), 32'h0);
      repeat (3) tick();
      chk("credit_still_low", 32'(req_ready), 32'h0);
      rsp_ready = 1'b1;
      tick();
      chk("credit_ready_back", 32'(req_ready), 32'h1);
      drain();

      // Asynchronous reset with two reads in flight
      send(1'b0, 'h010, 2, 1'b0, 32'h0, 8'd20, 0);
      send(1'b0, 'h014, 2, 1'b0, 32'h0, 8'd21, 0);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      port_q.delete();
      #1;
      chk("midreset_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("midreset_rden", 32'(rden_b), 32'h0);
      chk("midreset_wren", 32'(wren_b), 32'h0);
      #3;
      rst_n = 1'b1;
      tick();
      chk("postreset_req_ready", 32'(req_ready), 32'h1);
      repeat (6) tick();
      send(1'b0, 'h010, 2, 1'b0, 32'h0, 8'd22, 1);
      drain();

      // Randomized traffic with random response backpressure
      rnd_ready = 1;
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 3) == 0) tick();
         size = int'($urandom_range(0, 3));
         addr = int'($urandom_range(0, 63));
         if (size < 3 && $urandom_range(0, 3) != 0) addr = addr & ~((1 << size) - 1);
         send(1'($urandom_range(0, 1)), addr, size, 1'($urandom_range(0, 1)),
              $urandom, TW'(n), 0);
      end
      rnd_ready = 0;
      #2;
      rsp_ready = 1'b1;
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
